// File: rtl/axil_cmd_queue_if.sv
// rtl/axil_cmd_queue_if.sv - command/response and master-side bundle for axil_cmd_queue
interface axil_cmd_queue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDRESS_WIDTH-1:0]  cmd_addr;
  logic [DATA_WIDTH/8-1:0]   cmd_wstrb;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_write;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic [1:0]                rsp_resp;
  logic                      rsp_timeout;
  logic                      wr_en;
  logic                      rd_en;
  logic [ADDRESS_WIDTH-1:0]  awaddr_out;
  logic [DATA_WIDTH/8-1:0]   wstrb_out;
  logic [DATA_WIDTH-1:0]     wdata_out;
  logic [ADDRESS_WIDTH-1:0]  araddr_out;
  logic [DATA_WIDTH-1:0]     rdata_in;
  logic [1:0]                rresp_in;
  logic [1:0]                bresp_in;
  logic                      txn_done;
  logic                      busy;

  // The queue itself
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wstrb, cmd_wdata,
    input  rsp_ready, rdata_in, rresp_in, bresp_in, txn_done,
    output cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_timeout,
    output wr_en, rd_en, awaddr_out, wstrb_out, wdata_out, araddr_out, busy
  );

  // The user plus the AXI4-Lite master it drives
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wstrb, cmd_wdata,
    output rsp_ready, rdata_in, rresp_in, bresp_in, txn_done,
    input  cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_resp, rsp_timeout,
    input  wr_en, rd_en, awaddr_out, wstrb_out, wdata_out, araddr_out, busy
  );
endinterface

// File: rtl/axil_cmd_queue.sv
// rtl/axil_cmd_queue.sv - in-order AXI4-Lite command sequencer with FIFO and watchdog
module axil_cmd_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 4,
  parameter int TIMEOUT       = 256
) (
  input logic             clk,
  input logic             rst,
  axil_cmd_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW:0]   FULL  = (PW + 1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_next;

  logic                     q_write [DEPTH];
  logic [ADDRESS_WIDTH-1:0] q_addr  [DEPTH];
  logic [SW-1:0]            q_wstrb [DEPTH];
  logic [DATA_WIDTH-1:0]    q_wdata [DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              count;
  logic                     push, pop;
  logic                     cur_write;
  logic [TW-1:0]            timer;
  logic                     expired;

  // cmd_ready comes from the registered count only, so a pop at full never frees a same-cycle push
  assign bus.cmd_ready = (count != FULL);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != '0);
  assign expired       = (TIMEOUT != 0) && (timer == TLAST);
  assign bus.wr_en     = (state == ISSUE) && cur_write;
  assign bus.rd_en     = (state == ISSUE) && !cur_write;
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE) || (count != '0);

  // Command storage; contents are don't-care until the count says otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      q_write[wr_ptr] <= bus.cmd_write;
      q_addr[wr_ptr]  <= bus.cmd_addr;
      q_wstrb[wr_ptr] <= bus.cmd_wstrb;
      q_wdata[wr_ptr] <= bus.cmd_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Sequencer: one command in flight, response must be taken before the next issue
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.txn_done || expired) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FIFO pointers, issue registers, watchdog timer and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cur_write       <= 1'b0;
      timer           <= '0;
      bus.awaddr_out  <= '0;
      bus.wstrb_out   <= '0;
      bus.wdata_out   <= '0;
      bus.araddr_out  <= '0;
      bus.rsp_write   <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_resp    <= 2'b00;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW + 1)'(1);
      else if (pop && !push) count <= count - (PW + 1)'(1);

      // Only the channel of the popped command is reloaded; the other holds
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        cur_write <= q_write[rd_ptr];
        if (q_write[rd_ptr]) begin
          bus.awaddr_out <= q_addr[rd_ptr];
          bus.wstrb_out  <= q_wstrb[rd_ptr];
          bus.wdata_out  <= q_wdata[rd_ptr];
        end else begin
          bus.araddr_out <= q_addr[rd_ptr];
        end
      end

      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT) begin
        // A completion on the expiry cycle wins over the watchdog
        if (bus.txn_done) begin
          bus.rsp_write   <= cur_write;
          bus.rsp_resp    <= cur_write ? bus.bresp_in : bus.rresp_in;
          bus.rsp_data    <= cur_write ? '0 : bus.rdata_in;
          bus.rsp_timeout <= 1'b0;
        end else if (expired) begin
          bus.rsp_write   <= cur_write;
          bus.rsp_resp    <= 2'b10;
          bus.rsp_data    <= '0;
          bus.rsp_timeout <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end
endmodule
